addsub_seq_ctrl: RTL
====================

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (even, >= 2); processed 2 bits per cycle.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start_valid  input  1  requester presents an operation.
REQ-005 SHALL have port: start_ready  output  1  controller can accept an operation.
REQ-006 SHALL have port: op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-007 SHALL have ports: a, b  input  WIDTH  operands, unsigned/two's complement.
REQ-008 SHALL have port: result  output  WIDTH  sum/difference, mod 2^WIDTH.
REQ-009 SHALL have port: carry_out  output  1  add: unsigned carry; sub: 1 = no borrow (a >= b unsigned).
REQ-010 SHALL have port: done_valid  output  1  result/carry_out valid.
REQ-011 SHALL have port: done_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL assert start_ready only in IDLE; accept = start_valid && start_ready.
REQ-015 SHALL on accept latch a, b, op, clear slice index to 0, load carry register with op, go to RUN.
REQ-016 SHALL in each RUN cycle i compute slice bits [2i+1:2i] = a_slice + (op ? ~b_slice : b_slice) + carry, write into result register, update carry.
REQ-017 SHALL spend exactly WIDTH/2 cycles in RUN, then go to DONE; done_valid high first cycle after last slice.
REQ-018 SHALL ignore a, b, op, start_valid changes while busy.
REQ-019 SHALL hold done_valid, result, carry_out stable in DONE until done_ready high (backpressure, no limit).
REQ-020 SHALL on done_valid && done_ready return to IDLE next cycle; no accept in the same cycle as result handoff.
REQ-021 SHALL keep result and carry_out at last completed values in IDLE until next accept overwrites progressively.
REQ-022 SHALL produce correct wrap-around: add overflow drops carry into carry_out; sub a<b yields two's complement, carry_out 0.
REQ-023 SHALL handle WIDTH=2 with one RUN cycle.

Reset
REQ-024 SHALL on rst_n low at a clock edge: state IDLE, result 0, carry_out 0, done_valid 0, busy 0, slice index 0, carry register 0.
REQ-025 SHALL abort any RUN/DONE operation on reset; partial result discarded; start_ready high first cycle after rst_n returns high.
REQ-026 SHALL give reset priority over all handshakes in the same cycle.

Configuration
REQ-027 SHALL, with macro ADDSUB_SEQ_OVERFLOW_EN defined, add port overflow  output  1  signed overflow = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]), b' = op ? ~b : b; valid with done_valid, 0 at reset, held like result.
REQ-028 SHALL, without ADDSUB_SEQ_OVERFLOW_EN, have no overflow port and no associated logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-029 SHALL cover: add 0x0F+0x01, done_ready=1 -> result 0x10, carry_out 0, done_valid exactly 5 cycles after accept edge (4 RUN + DONE entry).
REQ-030 SHALL cover: add 0xFF+0x01 -> result 0x00, carry_out 1, overflow 0 (macro on).
REQ-031 SHALL cover: sub 0x05-0x07 -> result 0xFE, carry_out 0, overflow 0; sub 0x80-0x01 -> 0x7F, carry_out 1, overflow 1.
REQ-032 SHALL cover: done_ready held 0 for 10 cycles -> done_valid, result stable, start_ready 0, new start_valid ignored; release -> IDLE next cycle.
REQ-033 SHALL cover: operand change mid-RUN -> result equals latched operands' result.
REQ-034 SHALL cover: rst_n low in 2nd RUN cycle -> next cycle all outputs 0, start_ready 1 after release; following add 0x01+0x01 -> 0x02.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// Serial add/subtract controller: consumes two operand bits per cycle with a valid/ready handshake.
// Define ADDSUB_SEQ_OVERFLOW_EN to add the signed-overflow output.
module addsub_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [1:0] a_sl, b_sl, b_eff;
  logic [2:0] slice_sum;
  logic       last_slice;

  // Current 2-bit slice of the latched operands and its sum with the running carry.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < SLICES; s++) begin
      if (idx_q == IDX_W'(s)) begin
        a_sl = a_q[2*s +: 2];
        b_sl = b_q[2*s +: 2];
      end
    end
    b_eff      = op_q ? ~b_sl : b_sl;
    slice_sum  = {1'b0, a_sl} + {1'b0, b_eff} + {2'b00, carry_q};
    last_slice = (idx_q == LAST_IDX);
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = op;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int s = 0; s < SLICES; s++) begin
          if (idx_q == IDX_W'(s)) result_d[2*s +: 2] = slice_sum[1:0];
        end
        carry_d = slice_sum[2];
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  // NOTE: operand latches are left unreset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

`ifdef ADDSUB_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Signed overflow is decided on the top slice, where the operand sign bits live.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last_slice)
      ovf_d = (a_sl[1] == b_eff[1]) && (slice_sum[1] != a_sl[1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done_valid  = (state_q == DONE);
  assign result      = result_q;
  assign carry_out   = carry_q;

endmodule
